dht11_poll_scheduler: RTL and testbench

Controller that sequences the DHT11 reader. It gates the reader's enable line and decides when reads happen:
- periodic polls and on-demand host requests,
- a minimum inter-read gap,
- timeouts and retries.

Each good sample is latched for downstream cold-storage logic. The block sits between the system timebase/host and the DHT11 reader, and is the only driver of the reader's enable.

---
 rtl/dht11_poll_scheduler_if.sv | 24 ++
 rtl/dht11_poll_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_dht11_poll_scheduler.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/dht11_poll_scheduler_if.sv
// rtl/dht11_poll_scheduler_if.sv - link between the poll scheduler and the DHT11 reader
interface dht11_poll_scheduler_if;
  logic       sensor_en;
  logic       sensor_ready;
  logic       sensor_csum_ok;
  logic [7:0] sensor_hum;
  logic [7:0] sensor_temp;

  modport master (
    output sensor_en,
    input  sensor_ready,
    input  sensor_csum_ok,
    input  sensor_hum,
    input  sensor_temp
  );

  modport slave (
    input  sensor_en,
    output sensor_ready,
    output sensor_csum_ok,
    output sensor_hum,
    output sensor_temp
  );
endinterface

// File: rtl/dht11_poll_scheduler.sv
// rtl/dht11_poll_scheduler.sv - DHT11 read sequencer: polls/requests, min gap, timeout, retries
// Optional threshold alarm built only when DHT_ALARM_EN is defined.
module dht11_poll_scheduler #(
  parameter int POLL_PERIOD_CYC = 3000000,
  parameter int MIN_GAP_CYC     = 2000000,
  parameter int TIMEOUT_CYC     = 30000,
  parameter int MAX_RETRY       = 3,
  parameter int CNT_W           = 24
`ifdef DHT_ALARM_EN
  ,
  parameter int TEMP_HI = 35,
  parameter int HUM_HI  = 45
`endif
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          req,
  dht11_poll_scheduler_if.master        sif,
  output logic [7:0]                    humidity,
  output logic [7:0]                    temperature,
  output logic                          sample_valid,
  output logic                          read_err,
  output logic                          fault,
  output logic                          busy,
  output logic                          alarm
);
  typedef enum logic [1:0] {IDLE, READ, CHECK, WAIT} state_t;

  localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_PERIOD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_MIN   = CNT_W'(MIN_GAP_CYC);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRY);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] poll_cnt_q, poll_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic [2:0]       retry_q, retry_d;
  logic             pending_q, pending_d;
  logic             ok_q, ok_d;
  logic [7:0]       cap_hum_q, cap_hum_d, cap_temp_q, cap_temp_d;
  logic [7:0]       hum_q, hum_d, temp_q, temp_d;
  logic             sample_valid_q, sample_valid_d;
  logic             read_err_q, read_err_d;
  logic             fault_q, fault_d;
  logic             tick, gap_ok, launch;

  always_comb begin
    tick   = en && (poll_cnt_q == POLL_LAST);
    gap_ok = (gap_cnt_q >= GAP_MIN);
    // A request, tick and stored pending all collapse into a single launch.
    launch = (state_q == IDLE) && en && gap_ok && (pending_q || tick || req);

    state_d        = state_q;
    poll_cnt_d     = poll_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    to_cnt_d       = '0;
    retry_d        = retry_q;
    ok_d           = ok_q;
    cap_hum_d      = cap_hum_q;
    cap_temp_d     = cap_temp_q;
    hum_d          = hum_q;
    temp_d         = temp_q;
    sample_valid_d = 1'b0;
    read_err_d     = 1'b0;
    fault_d        = fault_q;

    if (en) poll_cnt_d = tick ? '0 : poll_cnt_q + 1'b1;
    pending_d = launch ? 1'b0 : (pending_q || tick || req);

    if (!en) begin
      state_d = IDLE;
      retry_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (launch) begin
            state_d = READ;
            retry_d = 3'd1;
          end
        end
        READ: begin
          if (sif.sensor_ready) begin
            state_d    = CHECK;
            ok_d       = sif.sensor_csum_ok;
            cap_hum_d  = sif.sensor_hum;
            cap_temp_d = sif.sensor_temp;
          end else if (to_cnt_q == TO_LAST) begin
            state_d = CHECK;
            ok_d    = 1'b0;
          end
        end
        CHECK: begin
          if (ok_q) begin
            hum_d          = cap_hum_q;
            temp_d         = cap_temp_q;
            sample_valid_d = 1'b1;
            fault_d        = 1'b0;
            state_d        = IDLE;
          end else if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 3'd1;
            state_d = WAIT;
          end else begin
            read_err_d = 1'b1;
            fault_d    = 1'b1;
            state_d    = IDLE;
          end
        end
        WAIT: begin
          if (gap_ok) state_d = READ;
        end
        default: state_d = IDLE;
      endcase
    end

    if (state_q == READ && state_d == READ) to_cnt_d = to_cnt_q + 1'b1;

    // Gap restarts on every READ exit and on any abort; otherwise it counts while the reader is off.
    if ((state_q == READ && state_d != READ) || (!en && state_q != IDLE))
      gap_cnt_d = '0;
    else if (state_q != READ && gap_cnt_q < GAP_MIN)
      gap_cnt_d = gap_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      poll_cnt_q     <= '0;
      gap_cnt_q      <= '0;
      to_cnt_q       <= '0;
      retry_q        <= '0;
      pending_q      <= 1'b0;
      ok_q           <= 1'b0;
      cap_hum_q      <= '0;
      cap_temp_q     <= '0;
      hum_q          <= '0;
      temp_q         <= '0;
      sample_valid_q <= 1'b0;
      read_err_q     <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      poll_cnt_q     <= poll_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      to_cnt_q       <= to_cnt_d;
      retry_q        <= retry_d;
      pending_q      <= pending_d;
      ok_q           <= ok_d;
      cap_hum_q      <= cap_hum_d;
      cap_temp_q     <= cap_temp_d;
      hum_q          <= hum_d;
      temp_q         <= temp_d;
      sample_valid_q <= sample_valid_d;
      read_err_q     <= read_err_d;
      fault_q        <= fault_d;
    end
  end

  assign sif.sensor_en = (state_q == READ);
  assign busy          = (state_q != IDLE);
  assign humidity      = hum_q;
  assign temperature   = temp_q;
  assign sample_valid  = sample_valid_q;
  assign read_err      = read_err_q;
  assign fault         = fault_q;

`ifdef DHT_ALARM_EN
  logic alarm_q, alarm_d;

  always_comb begin
    alarm_d = (temp_q > 8'(TEMP_HI)) || (hum_q > 8'(HUM_HI));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) alarm_q <= 1'b0;
    else        alarm_q <= alarm_d;
  end

  assign alarm = alarm_q;
`else
  assign alarm = 1'b0;
`endif
endmodule

// File: tb/tb_dht11_poll_scheduler.sv
// tb/tb_dht11_poll_scheduler.sv - directed scoreboard bench for dht11_poll_scheduler
module tb_dht11_poll_scheduler;
  localparam int POLL = 1000;
  localparam int GAP  = 200;
  localparam int TO   = 100;
  localparam int NRET = 2;
`ifdef DHT_ALARM_EN
  localparam logic ALARM_HOT = 1'b1;
`else
  localparam logic ALARM_HOT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, en, req;
  logic [7:0] humidity, temperature;
  logic       sample_valid, read_err, fault, busy, alarm;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [15:0] sb[$];

  dht11_poll_scheduler_if sif ();

  dht11_poll_scheduler #(
    .POLL_PERIOD_CYC(POLL), .MIN_GAP_CYC(GAP), .TIMEOUT_CYC(TO), .MAX_RETRY(NRET), .CNT_W(24)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .sif(sif),
    .humidity(humidity), .temperature(temperature), .sample_valid(sample_valid),
    .read_err(read_err), .fault(fault), .busy(busy), .alarm(alarm)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; req = 1'b0;
    sif.sensor_ready = 1'b0; sif.sensor_csum_ok = 1'b0;
    sif.sensor_hum = 8'h00; sif.sensor_temp = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst sensor_en", sif.sensor_en, 0);
    chk("rst busy", busy, 0);
    chk("rst outs", {humidity, temperature, sample_valid, read_err, fault, alarm}, 0);
    rst_n = 1'b1; en = 1'b1;
  endtask

  task automatic pulse_req();
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_sen(input string tag, input int bound, output int seen);
    int n = 0;
    while (sif.sensor_en !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " sensor_en rise"}, sif.sensor_en, 1);
    seen = cyc;
  endtask

  task automatic count_high(output int n);
    n = 0;
    while (sif.sensor_en === 1'b1 && n < 4 * TO) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Called at a negedge with sensor_en high; returns the cycle ready was driven, ends 2 cycles later.
  task automatic respond(input string tag, input int delay, input logic ok, input logic [7:0] h,
                         input logic [7:0] t, input int req_at, output int r);
    logic [15:0] e;
    for (int i = 0; i < delay; i++) begin
      req = (req_at >= 0) && (i >= req_at) && (i < req_at + 3);
      @(negedge clk);
    end
    req = 1'b0;
    chk({tag, " en held"}, sif.sensor_en, 1);
    sif.sensor_ready = 1'b1; sif.sensor_csum_ok = ok;
    sif.sensor_hum = h; sif.sensor_temp = t;
    if (ok) sb.push_back({h, t});
    r = cyc;
    @(negedge clk);
    sif.sensor_ready = 1'b0; sif.sensor_csum_ok = 1'b0;
    sif.sensor_hum = 8'($urandom); sif.sensor_temp = 8'($urandom);
    chk({tag, " en drop"}, sif.sensor_en, 0);
    chk({tag, " sv early"}, sample_valid, 0);
    @(negedge clk);
    chk({tag, " sample_valid"}, sample_valid, ok);
    if (sample_valid === 1'b1) begin
      chk({tag, " sb nonempty"}, sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({tag, " humidity"}, humidity, e[15:8]);
        chk({tag, " temperature"}, temperature, e[7:0]);
      end
    end
  endtask

  initial begin
    int s, r, r2, a, n, hits;

    // 1: automatic poll with no request
    do_reset();
    wait_sen("t1", 2 * POLL, s);
    chk("t1 poll start", s, POLL);
    respond("t1", 50, 1'b1, 8'h28, 8'h21, -1, r);
    chk("t1 fault", fault, 0);

    // 2a: early request waits out power-up gap; burst of requests in READ gives one more read
    do_reset();
    repeat (100) @(negedge clk);
    pulse_req();
    wait_sen("t2", 4 * GAP, s);
    chk("t2 gap start", s, GAP + 1);
    respond("t2a", 20, 1'b1, 8'h11, 8'h22, 5, r);
    wait_sen("t2b", 4 * GAP, s);
    chk("t2 second start", s, r + GAP + 2);
    respond("t2b", 20, 1'b1, 8'h12, 8'h23, -1, r);
    hits = 0;
    repeat (300) begin
      @(negedge clk);
      if (sif.sensor_en === 1'b1) hits++;
    end
    chk("t2 single read", hits, 0);

    // 2b: request with gap already satisfied
    do_reset();
    repeat (300) @(negedge clk);
    pulse_req();
    chk("t2 req latency cyc", cyc, 301);
    chk("t2 req latency en", sif.sensor_en, 1);
    respond("t2c", 10, 1'b1, 8'h13, 8'h24, -1, r);

    // 3: checksum failures exhaust retries, then a good read clears fault
    do_reset();
    pulse_req();
    wait_sen("t3", 4 * GAP, s);
    respond("t3 good", 10, 1'b1, 8'h30, 8'h18, -1, r);
    pulse_req();
    wait_sen("t3 a1", 4 * GAP, s);
    chk("t3 a1 start", s, r + GAP + 2);
    respond("t3 a1", 10, 1'b0, 8'h77, 8'h66, -1, r);
    chk("t3 no err yet", read_err, 0);
    chk("t3 busy wait", busy, 1);
    wait_sen("t3 a2", 4 * GAP, s);
    chk("t3 retry gap", s, r + GAP + 2);
    respond("t3 a2", 10, 1'b0, 8'h55, 8'h44, -1, r2);
    chk("t3 read_err", read_err, 1);
    chk("t3 fault", fault, 1);
    chk("t3 hold outs", {humidity, temperature}, 16'h3018);
    @(negedge clk);
    chk("t3 err pulse", read_err, 0);
    pulse_req();
    wait_sen("t3 a3", 4 * GAP, s);
    chk("t3 recover start", s, r2 + GAP + 2);
    respond("t3 recover", 10, 1'b1, 8'h31, 8'h19, -1, r);
    chk("t3 fault clear", fault, 0);

    // 4: reader never answers
    do_reset();
    pulse_req();
    wait_sen("t4 a1", 4 * GAP, s);
    count_high(n);
    chk("t4 a1 window", n, TO);
    a = cyc;
    wait_sen("t4 a2", 4 * GAP, s);
    chk("t4 retry start", s, a + GAP + 1);
    count_high(n);
    chk("t4 a2 window", n, TO);
    chk("t4 err early", read_err, 0);
    @(negedge clk);
    chk("t4 read_err", read_err, 1);
    chk("t4 busy", busy, 0);
    chk("t4 fault", fault, 1);
    @(negedge clk);
    chk("t4 err pulse", read_err, 0);

    // 5: enable dropped mid-read
    do_reset();
    pulse_req();
    wait_sen("t5", 4 * GAP, s);
    repeat (4) @(negedge clk);
    pulse_req();
    repeat (5) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    a = cyc;
    chk("t5 abort en", sif.sensor_en, 0);
    chk("t5 abort busy", busy, 0);
    repeat (3) begin
      chk("t5 no err/sv", {read_err, sample_valid}, 0);
      @(negedge clk);
    end
    en = 1'b1;
    wait_sen("t5 restart", 4 * GAP, s);
    chk("t5 restart gap", s, a + GAP + 1);
    respond("t5", 10, 1'b1, 8'h20, 8'h15, -1, r);

    // 6: threshold alarm
    do_reset();
    pulse_req();
    wait_sen("t6 a", 4 * GAP, s);
    respond("t6 hot", 10, 1'b1, 8'd40, 8'd36, -1, r);
    chk("t6 alarm same", alarm, 0);
    @(negedge clk);
    chk("t6 alarm hot", alarm, ALARM_HOT);
    pulse_req();
    wait_sen("t6 b", 4 * GAP, s);
    respond("t6 cool", 10, 1'b1, 8'd40, 8'd30, -1, r);
    @(negedge clk);
    chk("t6 alarm cool", alarm, 0);

    chk("sb drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
